// File: rtl/icb_sram_slave_pkg.sv
// Shared constants and types for the ICB SRAM responder.
// Also provides the MemBus/MemAddrBus bus-width defines when the surrounding codebase has not.
`ifndef MemBus
`define MemBus 31:0
`endif
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif

package icb_sram_slave_pkg;

    localparam int ICB_RSP_DEPTH = 2;
    localparam int ICB_WMASK_W   = 4;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } rsp_entry_t;

endpackage

// File: rtl/icb_sram_slave_rsp_fifo.sv
// Two-entry in-order response FIFO of {err, rdata}.
// A push and a pop in the same cycle leave the count unchanged.
module icb_rsp_fifo
    import icb_sram_slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  rsp_entry_t push_data,
    input  logic       pop,
    output rsp_entry_t head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    rsp_entry_t mem_q [ICB_RSP_DEPTH];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                count_q <= count_q + 2'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 2'd1;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

endmodule

// File: rtl/icb_sram_slave.sv
// ICB slave wrapping a single-port synchronous word RAM with a 2-entry read response buffer.
// Optional ICB_SRAM_RANGE_CHK_EN: flag addresses beyond the RAM as errors instead of aliasing.
module icb_sram_slave
    import icb_sram_slave_pkg::*;
#(
    parameter int AW        = 10,
    parameter int RSP_DEPTH = ICB_RSP_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   icb_cmd_valid,
    output logic                   icb_cmd_ready,
    input  logic [`MemAddrBus]     icb_cmd_addr,
    input  logic                   icb_cmd_read,
    input  logic [`MemBus]         icb_cmd_wdata,
    input  logic [ICB_WMASK_W-1:0] icb_cmd_wmask,
    output logic                   icb_rsp_valid,
    input  logic                   icb_rsp_ready,
    output logic                   icb_rsp_err,
    output logic [`MemBus]         icb_rsp_rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] ram_q;
    logic [AW-1:0] word_idx;
    logic        oor;
    logic        rdy_q;
    logic        inflight_q;
    logic        rd_err_q;
    logic        cmd_hs, rd_hs, wr_hs;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]  fifo_count;
    rsp_entry_t  fifo_head, inflight_entry, rsp_entry;

    assign word_idx = icb_cmd_addr[AW+1:2];

`ifdef ICB_SRAM_RANGE_CHK_EN
    assign oor = |icb_cmd_addr[28:AW+2];
    logic unused_addr;
    assign unused_addr = ^{icb_cmd_addr[31:29], icb_cmd_addr[1:0], fifo_full};
`else
    assign oor = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{icb_cmd_addr[31:AW+2], icb_cmd_addr[1:0], fifo_full};
`endif

    // Credit uses registered state only so cmd_ready never depends on rsp_ready or cmd_valid.
    assign icb_cmd_ready = rdy_q &&
        (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'(RSP_DEPTH));

    assign cmd_hs = icb_cmd_valid & icb_cmd_ready;
    assign rd_hs  = cmd_hs & icb_cmd_read;
    assign wr_hs  = cmd_hs & ~icb_cmd_read;

    always_ff @(posedge clk) begin
        if (wr_hs && !oor) begin
            for (int i = 0; i < ICB_WMASK_W; i++) begin
                if (icb_cmd_wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
                end
            end
        end
        if (rd_hs && !oor) begin
            ram_q <= mem[word_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q      <= 1'b0;
            inflight_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rdy_q      <= 1'b1;
            inflight_q <= rd_hs;
            if (rd_hs) begin
                rd_err_q <= oor;
            end
        end
    end

    assign inflight_entry.err   = rd_err_q;
    assign inflight_entry.rdata = rd_err_q ? 32'd0 : ram_q;

    // With the buffer empty the fresh RAM word is presented directly, giving latency 1;
    // it is only stored when the master does not take it in that cycle.
    assign fifo_pop  = ~fifo_empty & icb_rsp_ready;
    assign fifo_push = inflight_q & ~(fifo_empty & icb_rsp_ready);

    icb_rsp_fifo u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (inflight_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        rsp_entry = '0;
        if (!fifo_empty) begin
            rsp_entry = fifo_head;
        end else if (inflight_q) begin
            rsp_entry = inflight_entry;
        end
    end

    assign icb_rsp_valid = ~fifo_empty | inflight_q;
    assign icb_rsp_err   = rsp_entry.err;
    assign icb_rsp_rdata = rsp_entry.rdata;

endmodule

// File: tb/tb_icb_sram_slave.sv
// Scoreboard bench for icb_sram_slave: stimulus queues expected read beats, a monitor checks them.
// Honours ICB_SRAM_RANGE_CHK_EN when choosing expected out-of-range results.
module tb_icb_sram_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    icb_sram_slave #(.AW(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata)
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: each beat seen here is popped by the DUT at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && icb_rsp_valid && icb_rsp_ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {icb_rsp_err, icb_rsp_rdata}, 33'h1_dead_dead);
            end else begin
                check("rsp_beat", {icb_rsp_err, icb_rsp_rdata}, exp_q.pop_front());
            end
        end
    end

    // Issues one command; returns the number of edges it took to be accepted.
    task automatic do_cmd(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input logic [32:0] exp, output int cycles);
        logic acc;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wdata;
        icb_cmd_wmask = wmask;
        cycles = 0;
        acc = 1'b0;
        while (!acc && cycles < 200) begin
            @(negedge clk);
            acc = icb_cmd_ready;
            if (acc && rd) exp_q.push_back(exp);
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!acc) check("cmd_accept_timeout", 33'd0, 33'd1);
        icb_cmd_valid = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] m);
        int c;
        do_cmd(1'b0, addr, d, m, 33'd0, c);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [32:0] exp);
        int c;
        do_cmd(1'b1, addr, 32'd0, 4'd0, exp, c);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain", {32'd0, exp_q.size() != 0}, 33'd0);
    endtask

    initial begin
        int c, total, pops_at_c;
        logic [32:0] oor_exp, w0_exp;
        rst_n = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = '0;
        icb_cmd_wdata = '0;
        icb_cmd_wmask = '0;
        icb_rsp_ready = 1'b1;
        #12;
        check("reset_rsp_valid", {32'd0, icb_rsp_valid}, 33'd0);
        check("reset_rsp", {icb_rsp_err, icb_rsp_rdata}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {32'd0, icb_cmd_ready}, 33'd1);

        // Basic write then read with latency check; the write must not produce a beat.
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        check("no_rsp_for_write", {32'd0, icb_rsp_valid}, 33'd0);
        rd(32'h10, {1'b0, 32'hDEADBEEF});
        check("read_latency_1", {32'd0, icb_rsp_valid}, 33'd1);
        wait_drain();

        // Byte-masked write, read-after-write in the next cycle.
        wr(32'h20, 32'h11223344, 4'hF);
        wr(32'h20, 32'hAABBCCDD, 4'b0101);
        rd(32'h20, {1'b0, 32'h11BB33DD});
        wr(32'h24, 32'h55667788, 4'hF);
        wr(32'h24, 32'hFFFFFFFF, 4'b0000);
        rd(32'h24, {1'b0, 32'h55667788});
        wait_drain();

        // Back-pressure: two reads fill the credits, the third waits for a pop.
        wr(32'h0, 32'hA, 4'hF);
        wr(32'h4, 32'hB, 4'hF);
        wr(32'h8, 32'hC, 4'hF);
        icb_rsp_ready = 1'b0;
        rd(32'h0, {1'b0, 32'hA});
        rd(32'h4, {1'b0, 32'hB});
        repeat (3) @(posedge clk);
        #1;
        check("full_cmd_ready_low", {32'd0, icb_cmd_ready}, 33'd0);
        check("held_rsp_stable", {icb_rsp_err, icb_rsp_rdata}, {1'b0, 32'hA});
        n_pops = 0;
        fork
            begin
                do_cmd(1'b1, 32'h8, 32'd0, 4'd0, {1'b0, 32'hC}, c);
                pops_at_c = n_pops;
            end
            begin
                repeat (4) @(posedge clk);
                #2 icb_rsp_ready = 1'b1;
            end
        join
        check("third_after_pop", {32'd0, pops_at_c >= 1}, 33'd1);
        check("third_waited", {32'd0, c > 4}, 33'd1);
        wait_drain();

        // Streaming: 8 consecutive reads must each be accepted in one cycle.
        for (int i = 0; i < 8; i++) wr(32'h100 + 4 * i, 32'h1000_0000 + i * 32'h0101_0101, 4'hF);
        total = 0;
        for (int i = 0; i < 8; i++) begin
            do_cmd(1'b1, 32'h100 + 4 * i, 32'd0, 4'd0, {1'b0, 32'h1000_0000 + i * 32'h0101_0101}, c);
            total += c;
        end
        check("stream_cycles", 33'(total), 33'd8);
        wait_drain();

        // Out-of-range address handling.
`ifdef ICB_SRAM_RANGE_CHK_EN
        oor_exp = {1'b1, 32'h0};
        w0_exp  = {1'b0, 32'hA};
`else
        oor_exp = {1'b0, 32'h5};
        w0_exp  = {1'b0, 32'h5};
`endif
        wr(32'h1000, 32'h5, 4'hF);
        rd(32'h1000, oor_exp);
        rd(32'h0, w0_exp);
        wait_drain();

        // Reset with two responses buffered: they vanish and never reappear.
        icb_rsp_ready = 1'b0;
        rd(32'h4, {1'b0, 32'hB});
        rd(32'h8, {1'b0, 32'hC});
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rsp_drop", {32'd0, icb_rsp_valid}, 33'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rerst", {32'd0, icb_cmd_ready}, 33'd1);
        repeat (5) @(posedge clk);
        #1;
        check("no_stale_rsp", {32'd0, icb_rsp_valid}, 33'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
